// File: rtl/add_arbiter.sv
// Two-requester arbiter in front of a shared pipelined 8-bit adder.
// Bursty ownership with a fairness cap; a tag pipeline routes each sum back to its requester.
module add_arbiter #(
  parameter int unsigned MAX_BURST = 100,
  parameter int unsigned ADD_LAT   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       r0_valid,
  input  logic       r1_valid,
  output logic       r0_ready,
  output logic       r1_ready,
  input  logic [7:0] r0_a,
  input  logic [7:0] r0_b,
  input  logic [7:0] r1_a,
  input  logic [7:0] r1_b,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  input  logic [7:0] add_x,
  output logic       res0_valid,
  output logic       res1_valid,
  output logic [7:0] res_data,
  output logic [1:0] dbg_owner
);

  // Handshake: an operand pair transfers on a rising edge where rN_valid and rN_ready
  // are both 1; ready never rises without its valid and never for both requesters at once.

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       grant_vld, grant_id;
  logic       own_id, own_valid, oth_valid, under_cap;

  logic [ADD_LAT:0] tag_vld;
  logic [ADD_LAT:0] tag_id;

  assign own_id    = (owner_q == OWN_1);
  assign own_valid = own_id ? r1_valid : r0_valid;
  assign oth_valid = own_id ? r0_valid : r1_valid;
  assign under_cap = (cnt_q < MAX_BURST_C);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: continuing owner counts up; a new grantee (or a capped owner
  // re-granted because the other side is idle) restarts the burst at 1.
  always_comb begin
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (!grant_vld) begin
      owner_d = OWN_NONE;
      cnt_d   = 8'd0;
    end else if (owner_q != OWN_NONE && grant_id == own_id && under_cap) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      owner_d = grant_id ? OWN_1 : OWN_0;
      cnt_d   = 8'd1;
      last_d  = grant_id;
    end
  end

  // Output (grant) logic
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (owner_q == OWN_NONE) begin
      if (r0_valid && r1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_q;
      end else if (r0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (r1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end else if (own_valid && under_cap) begin
      grant_vld = 1'b1;
      grant_id  = own_id;
    end else if (oth_valid) begin
      grant_vld = 1'b1;
      grant_id  = ~own_id;
    end else if (own_valid) begin
      grant_vld = 1'b1;
      grant_id  = own_id;
    end
    if (reset) grant_vld = 1'b0;
  end

  assign r0_ready  = grant_vld && !grant_id;
  assign r1_ready  = grant_vld &&  grant_id;
  assign dbg_owner = owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      add_a <= 8'd0;
      add_b <= 8'd0;
    end else if (grant_vld) begin
      add_a <= grant_id ? r1_a : r0_a;
      add_b <= grant_id ? r1_b : r0_b;
    end
  end

  // Tag stage ADD_LAT lines up with the adder output for the same operands.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      tag_id  <= '0;
    end else begin
      tag_vld <= {tag_vld[ADD_LAT-1:0], grant_vld};
      tag_id  <= {tag_id[ADD_LAT-1:0], grant_id};
    end
  end

  assign res0_valid = !reset && tag_vld[ADD_LAT] && !tag_id[ADD_LAT];
  assign res1_valid = !reset && tag_vld[ADD_LAT] &&  tag_id[ADD_LAT];
  assign res_data   = add_x;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with MAX_BURST=4, ADD_LAT=1 and a one-cycle adder model.
module tb_add_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       r0_valid = 1'b0, r1_valid = 1'b0;
  logic       r0_ready, r1_ready;
  logic [7:0] r0_a = 8'd0, r0_b = 8'd0, r1_a = 8'd0, r1_b = 8'd0;
  logic [7:0] add_a, add_b;
  logic [7:0] add_x = 8'd0;
  logic       res0_valid, res1_valid;
  logic [7:0] res_data;
  logic [1:0] dbg_owner;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // {due cycle[24:9], id[8], sum[7:0]}
  logic [24:0] exp_q[$];

  always #5 clk = ~clk;

  // Shared adder, one cycle of latency
  always @(posedge clk) add_x <= add_a + add_b;

  add_arbiter #(.MAX_BURST(4), .ADD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r1_valid(r1_valid),
    .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
    .add_a(add_a), .add_b(add_b), .add_x(add_x),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res_data(res_data), .dbg_owner(dbg_owner)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_results();
    logic [24:0] e;
    if (res0_valid && res1_valid) check("res_both", {res1_valid, res0_valid}, 32'd1);
    if (res0_valid || res1_valid) begin
      if (exp_q.size() == 0) begin
        check("res_spurious", {res1_valid, res0_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("res_cyc", cyc, e[24:9]);
        check("res_id", res1_valid, e[8]);
        check("res_data", res_data, e[7:0]);
      end
    end else if (exp_q.size() > 0 && int'(exp_q[0][24:9]) == cyc) begin
      check("res_missing", 32'(res0_valid | res1_valid), 32'd1);
      void'(exp_q.pop_front());
    end
  endtask

  // One clock: check results and readies at the falling edge, then pass the rising edge.
  task automatic step(input bit e0, input bit e1, input logic [7:0] esum);
    logic [15:0] due;
    @(negedge clk);
    check_results();
    check("r0_ready", r0_ready, e0);
    check("r1_ready", r1_ready, e1);
    due = 16'(cyc + 2);
    if (e0 || e1) exp_q.push_back({due, e1, esum});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_r0_ready", r0_ready, 0);
      check("rst_r1_ready", r1_ready, 0);
      check("rst_res_valid", {res1_valid, res0_valid}, 0);
      @(posedge clk);
      cyc++;
      #1;
    end
    reset = 1'b0;
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_owner", dbg_owner, 0);
  endtask

  task automatic drain();
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic id;
    #1;
    // Reset with both requesters asking; r0 must win the first tie.
    r0_valid = 1'b1; r1_valid = 1'b1;
    hold_reset(3);

    // Both valid continuously: bursts of four alternate r0, r1, r0, r1.
    for (int k = 0; k < 16; k++) begin
      r0_a = 8'(k * 3); r0_b = 8'h10;
      r1_a = 8'(8'hF0 + k); r1_b = 8'h20;
      id = ((k / 4) % 2) == 1;
      step(!id, id, id ? 8'(r1_a + r1_b) : 8'(r0_a + r0_b));
    end
    drain();

    // Single r0 handshake: 0x12 + 0x34 = 0x46
    r0_valid = 1'b1; r0_a = 8'h12; r0_b = 8'h34;
    step(1, 0, 8'h46);
    drain();

    // Single r1 handshake with wrap: 0xFF + 0x02 = 0x01
    r1_valid = 1'b1; r1_a = 8'hFF; r1_b = 8'h02;
    step(0, 1, 8'h01);
    drain();

    // r0 alone, 10 back-to-back ops past the cap
    r0_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      r0_a = 8'(8'h80 + k * 7); r0_b = 8'(8'h90 + k);
      step(1, 0, 8'(r0_a + r0_b));
    end
    drain();

    // r0 drops mid-burst; r1 is served the very next cycle
    r0_valid = 1'b1; r0_a = 8'h01; r0_b = 8'h02;
    step(1, 0, 8'h03);
    r1_valid = 1'b1; r1_a = 8'h40; r1_b = 8'h05;
    step(1, 0, 8'h03);
    r0_valid = 1'b0;
    step(0, 1, 8'h45);
    drain();

    // Reset with two ops in flight discards both results
    r0_valid = 1'b1; r0_a = 8'h11; r0_b = 8'h22;
    step(1, 0, 8'h33);
    step(1, 0, 8'h33);
    r0_valid = 1'b0;
    exp_q.delete();
    hold_reset(2);
    r1_valid = 1'b1; r1_a = 8'h5A; r1_b = 8'h25;
    step(0, 1, 8'h7F);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish by 50000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 100, maximum consecutive accepts granted to one requester while the other is requesting (range 1..255).
REQ-002 Parameter: ADD_LAT, 1, clock cycles from the shared adder's operand inputs changing to its sum output reflecting them (range 1..4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 r0_valid / r1_valid  input  1 each  requester operand pair valid.
REQ-006 r0_ready / r1_ready  output  1 each  operand pair accepted this cycle (combinational).
REQ-007 r0_a, r0_b / r1_a, r1_b  input  8 each  requester operands.
REQ-008 add_a, add_b  output  8 each  registered operands to the shared adder (io_A, io_B).
REQ-009 add_x  input  8  sum from the shared adder (io_X).
REQ-010 res0_valid / res1_valid  output  1 each  result belongs to requester 0 / 1 this cycle.
REQ-011 res_data  output  8  result data; equals add_x.

Function
REQ-012 State: owner register {NONE, OWN0, OWN1}, last-served pointer (1 bit), burst counter (8 bits), and tag pipeline of ADD_LAT+1 stages, each stage {valid, id}.
REQ-013 Grant, combinational, at most one per cycle:
 - owner k, rk_valid=1, burst_cnt < MAX_BURST -> grant k;
 - else the other requester valid -> grant the other;
 - else rk_valid=1 with cap reached and the other idle -> grant k;
 - owner NONE -> the single valid requester; if both valid, the requester not last served.
REQ-014 rN_ready = 1 iff grant == N; no ready is issued without the matching valid.
REQ-015 On accept, add_a/add_b load the granted operands at that edge; with no accept they hold their values.
REQ-016 Accept by the current owner -> burst_cnt+1; accept by the other requester, or the cap-reached continuation of REQ-013 -> owner := grantee, burst_cnt := 1, last-served := grantee.
REQ-017 A cycle with no accept -> owner := NONE, burst_cnt := 0; last-served is unchanged.
REQ-018 Tag stage 0 loads {accept, grant id} each edge; each later stage shifts by one per edge.
REQ-019 resN_valid = final-stage valid AND final-stage id == N.
REQ-020 A result appears exactly ADD_LAT+1 cycles after its handshake edge and is valid for exactly one cycle; ordering equals accept order.
REQ-021 Throughput: one accept per cycle sustained, with no bubble at owner switches or cap boundaries.
REQ-022 Results have no backpressure; consumers are always ready.
REQ-023 Sum arithmetic is modulo 256 (adder behaviour); this block performs no arithmetic on data.
REQ-024 A requester dropping valid mid-burst ends its burst (REQ-017); the other requester is served the next cycle with no added delay.

Reset
REQ-025 While reset=1 at an edge:
 - owner := NONE, last-served := 1 so requester 0 wins the first tie;
 - burst_cnt := 0, add_a := 0, add_b := 0;
 - all tag stages invalid.
REQ-026 During reset, r0_ready, r1_ready, res0_valid and res1_valid are 0.
REQ-027 Reset mid-operation discards in-flight results: no resN_valid pulse for any pre-reset accept.

Verification
REQ-028 Reset held 3 cycles -> add_a=add_b=0; all ready and res_valid outputs 0; both requesters valid on the first post-reset cycle -> r0_ready=1.
REQ-029 r0: a=0x12, b=0x34 single handshake, ADD_LAT=1 -> res0_valid for one cycle, 2 cycles after the handshake edge, res_data=0x46, res1_valid=0.
REQ-030 r1: a=0xFF, b=0x02 -> res1_valid with res_data=0x01 (wrap).
REQ-031 MAX_BURST=4, both valid continuously -> grants r0 x4, r1 x4, r0 x4, ...; every result's res_valid id matches its requester; no idle cycle.
REQ-032 MAX_BURST=4, r0 only, 10 ops -> 10 accepts in 10 consecutive cycles; results in order.
REQ-033 Reset asserted with 2 ops in flight -> no res_valid for those ops; a new op after reset returns normally.
